// File: rtl/cordic_result_buffer.sv
// Result collector for cordic_top: tags in-flight requests with their mode, buffers
// {mode, result} pairs for a valid/ready consumer and issues credits to the requester.
module cordic_result_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MODE_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pre_valid,
    input  logic [MODE_W-1:0]          mode,
    output logic                       issue_ready,
    input  logic                       post_valid,
    input  logic [DATA_W-1:0]          result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MODE_W-1:0]          out_mode,
    output logic [DATA_W-1:0]          out_result,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_underflow,
    output logic                       err_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = MODE_W + DATA_W;

    logic [MODE_W-1:0] tag_mem_q [DEPTH];
    logic [EW-1:0]     out_mem_q [DEPTH];

    logic [CW-1:0] tag_wr_q, tag_wr_d;
    logic [CW-1:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0] out_wr_q, out_wr_d;
    logic [CW-1:0] out_rd_q, out_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_unf_q, err_unf_d;
    logic          err_ovf_q, err_ovf_d;

    logic [CW-1:0]     tag_count;
    logic [CW-1:0]     out_count;
    logic              tag_empty, tag_full;
    logic              out_empty, out_full;
    logic              out_pop, cnt_dec;
    logic              issue_ok, issue_acc;
    logic              tag_pop, tag_push, out_push;
    logic [MODE_W-1:0] popped_tag;
    logic [EW-1:0]     head;

    always_comb begin
        tag_count  = tag_wr_q - tag_rd_q;
        out_count  = out_wr_q - out_rd_q;
        tag_empty  = (tag_count == '0);
        tag_full   = (tag_count == CW'(DEPTH));
        out_empty  = (out_count == '0);
        out_full   = (out_count == CW'(DEPTH));

        out_pop    = !out_empty && out_ready;
        // Entries written on underflow carry no credit, so never count below zero.
        cnt_dec    = out_pop && (cnt_q != '0);
        // A credit returned by a same-cycle pop covers a concurrent issue.
        issue_ok   = (cnt_q < CW'(DEPTH)) || cnt_dec;
        issue_acc  = pre_valid && issue_ok;

        tag_pop    = post_valid && !tag_empty;
        tag_push   = issue_acc && (!tag_full || tag_pop);
        popped_tag = tag_empty ? '0 : tag_mem_q[tag_rd_q[AW-1:0]];
        out_push   = post_valid && (!out_full || out_pop);

        tag_wr_d   = tag_push ? tag_wr_q + CW'(1) : tag_wr_q;
        tag_rd_d   = tag_pop  ? tag_rd_q + CW'(1) : tag_rd_q;
        out_wr_d   = out_push ? out_wr_q + CW'(1) : out_wr_q;
        out_rd_d   = out_pop  ? out_rd_q + CW'(1) : out_rd_q;

        unique case ({issue_acc, cnt_dec})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        err_unf_d = err_unf_q || (post_valid && tag_empty);
        err_ovf_d = err_ovf_q || (pre_valid && !issue_ok) || (issue_acc && !tag_push)
                    || (post_valid && !out_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            cnt_q     <= '0;
            err_unf_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            cnt_q     <= cnt_d;
            err_unf_q <= err_unf_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Storage arrays need no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_q[AW-1:0]] <= mode;
        end
        if (out_push) begin
            out_mem_q[out_wr_q[AW-1:0]] <= {popped_tag, result};
        end
    end

    always_comb begin
        head          = out_mem_q[out_rd_q[AW-1:0]];
        out_valid     = !out_empty;
        // Gate the head so stale storage never shows after reset.
        out_mode      = out_valid ? head[EW-1:DATA_W] : '0;
        out_result    = out_valid ? head[DATA_W-1:0] : '0;
        issue_ready   = (cnt_q < CW'(DEPTH));
        level         = out_count;
        outstanding   = cnt_q;
        err_underflow = err_unf_q;
        err_overflow  = err_ovf_q;
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Scoreboard bench for cordic_result_buffer: queue-based reference model, random traffic
// plus directed credit, underflow and reset scenarios.
module tb_cordic_result_buffer;

    localparam int DATA_W = 32;
    localparam int MODE_W = 4;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pre_valid = 1'b0;
    logic [MODE_W-1:0] mode = '0;
    logic              issue_ready;
    logic              post_valid = 1'b0;
    logic [DATA_W-1:0] result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MODE_W-1:0] out_mode;
    logic [DATA_W-1:0] out_result;
    logic [CW-1:0]     level;
    logic [CW-1:0]     outstanding;
    logic              err_underflow;
    logic              err_overflow;

    cordic_result_buffer #(
        .DATA_W(DATA_W),
        .MODE_W(MODE_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pre_valid    (pre_valid),
        .mode         (mode),
        .issue_ready  (issue_ready),
        .post_valid   (post_valid),
        .result       (result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_result   (out_result),
        .level        (level),
        .outstanding  (outstanding),
        .err_underflow(err_underflow),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [MODE_W-1:0]        tag_q [$];
    logic [MODE_W+DATA_W-1:0] exp_q [$];
    int   m_out   = 0;
    int   m_level = 0;
    logic m_ovf   = 1'b0;
    logic m_unf   = 1'b0;
    bit   run     = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        tag_q.delete();
        exp_q.delete();
        m_out   = 0;
        m_level = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Apply one clock edge's worth of rules to the model, using the inputs held at that edge.
    task automatic model_edge();
        bit                dec;
        bit                acc;
        logic [MODE_W-1:0] tg;
        dec = (m_level > 0) && out_ready;
        acc = pre_valid && ((m_out < DEPTH) || dec);
        tg  = '0;
        if (pre_valid && !acc) m_ovf = 1'b1;
        if (post_valid) begin
            if (tag_q.size() == 0) m_unf = 1'b1;
            else tg = tag_q.pop_front();
        end
        if (acc) begin
            if (tag_q.size() < DEPTH) tag_q.push_back(mode);
            else m_ovf = 1'b1;
        end
        if (post_valid) begin
            if ((m_level < DEPTH) || dec) begin
                exp_q.push_back({tg, result});
                m_level++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (dec) m_level--;
        m_out = m_out + (acc ? 1 : 0) - ((dec && m_out > 0) ? 1 : 0);
    endtask

    // Called at posedge+1; inputs stay stable across the following posedge.
    task automatic cycle(input logic pv, input logic [MODE_W-1:0] md, input logic pov,
                         input logic [DATA_W-1:0] res, input logic ordy);
        pre_valid  = pv;
        mode       = md;
        post_valid = pov;
        result     = res;
        out_ready  = ordy;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, '0, ordy);
    endtask

    task automatic drain();
        while (tag_q.size() > 0) cycle(1'b0, '0, 1'b1, 32'($urandom), 1'b1);
        repeat (DEPTH + 2) idle(1'b1);
    endtask

    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        model_clear();
        pre_valid  = 1'b0;
        post_valid = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_err_ovf", err_overflow, 0);
        chk("rst_err_unf", err_underflow, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_level", level, 0);
    endtask

    task automatic random_phase(input int n, input bit legal);
        bit pv, pov;
        for (int i = 0; i < n; i++) begin
            if (legal) begin
                pv  = ($urandom % 2 == 0) && (m_out < DEPTH);
                pov = (tag_q.size() > 0) && ($urandom % 3 != 0);
            end else begin
                pv  = ($urandom % 2 == 0);
                pov = ($urandom % 2 == 0);
            end
            cycle(pv, 4'($urandom_range(0, 9)), pov, 32'($urandom), ($urandom % 3 != 0));
        end
    endtask

    // Monitor: compares state every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("issue_ready", issue_ready, (m_out < DEPTH) ? 1 : 0);
            chk("level", level, 64'(m_level));
            chk("outstanding", outstanding, 64'(m_out));
            chk("out_valid", out_valid, (m_level > 0) ? 1 : 0);
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_underflow", err_underflow, m_unf);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    chk("out_mode", out_mode, exp_q[0][DATA_W+MODE_W-1:DATA_W]);
                    chk("out_result", out_result, exp_q[0][DATA_W-1:0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_issue_ready", issue_ready, 1);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_mode", out_mode, 0);
        chk("init_out_result", out_result, 0);
        chk("init_level", level, 0);
        chk("init_outstanding", outstanding, 0);
        chk("init_errs", {err_overflow, err_underflow}, 0);
        rst = 1'b0;
        run = 1'b1;

        // Single sin request
        cycle(1'b1, 4'd0, 1'b0, '0, 1'b1);
        repeat (3) idle(1'b1);
        cycle(1'b0, '0, 1'b1, 32'd32768, 1'b1);
        chk("sin_out_valid", out_valid, 1);
        chk("sin_out_mode", out_mode, 0);
        chk("sin_out_result", out_result, 32768);
        idle(1'b1);
        chk("sin_drained_valid", out_valid, 0);
        chk("sin_drained_outstanding", outstanding, 0);

        // Back-to-back cos requests, results on consecutive cycles
        cycle(1'b1, 4'd1, 1'b0, '0, 1'b1);
        cycle(1'b1, 4'd1, 1'b0, '0, 1'b1);
        idle(1'b1);
        cycle(1'b0, '0, 1'b1, 32'd56756, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'd32768, 1'b1);
        repeat (3) idle(1'b1);
        chk("b2b_outstanding", outstanding, 0);

        random_phase(1500, 1'b1);
        drain();

        // Credit exhaustion
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'(i % 10), 1'b0, '0, 1'b0);
        chk("exh_issue_ready", issue_ready, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 32'($urandom), 1'b0);
        chk("exh_level", level, DEPTH);
        cycle(1'b1, 4'd3, 1'b0, '0, 1'b0);
        chk("exh_err_overflow", err_overflow, 1);
        chk("exh_outstanding", outstanding, DEPTH);

        // Pop and issue together at full
        cycle(1'b1, 4'd2, 1'b0, '0, 1'b1);
        chk("sim_outstanding", outstanding, DEPTH);
        chk("sim_issue_ready", issue_ready, 0);
        idle(1'b1);
        chk("sim_next_issue_ready", issue_ready, 1);
        drain();
        pulse_reset();

        // Underflow
        cycle(1'b0, '0, 1'b1, 32'd45426, 1'b0);
        chk("unf_err", err_underflow, 1);
        chk("unf_out_mode", out_mode, 0);
        chk("unf_out_result", out_result, 45426);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stream: 5 buffered, 3 in flight
        pulse_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom_range(0, 9)), 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 32'($urandom), 1'b0);
        chk("mid_level", level, 5);
        chk("mid_outstanding", outstanding, 8);
        pulse_reset();

        random_phase(600, 1'b1);
        random_phase(600, 1'b0);
        pulse_reset();
        random_phase(200, 1'b1);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
